// File: rtl/hamenc_pkg.sv
// -----------------------------------------------------------------------------
// hamenc_pkg
// Shared definitions for the Hamming (16,11) SECDED encode sequencer:
//   - state_e  : sequencer states IDLE .. DONE
//   - MSG_W    : message width (11 data bits)
//   - CODE_W   : codeword width (16 bits)
//   - calc_p0  : overall parity over data and the four Hamming parity bits
// -----------------------------------------------------------------------------
package hamenc_pkg;

    localparam int MSG_W  = 11;
    localparam int CODE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_CAP   = 3'd3,
        ST_WR_LO = 3'd4,
        ST_WR_HI = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Overall parity: XOR of every data bit and every Hamming parity bit,
    // i.e. of codeword bits [15:1].
    function automatic logic calc_p0(input logic [MSG_W:1] d,
                                     input logic [3:0]     p);
        return (^d) ^ (^p);
    endfunction

endpackage

// File: rtl/hamming_enc11.sv
// -----------------------------------------------------------------------------
// hamming_enc11
// Purely combinational Hamming (16,11) encoder.
//   d    in  [11:1]  message bits d11..d1
//   code out [15:0]  {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}
// Build option HAMENC_P0_EN: when defined, code[0] carries the overall
// parity (SECDED); when undefined, code[0] is tied to 0 (SEC only).
// -----------------------------------------------------------------------------
module hamming_enc11
    import hamenc_pkg::*;
(
    input  logic [MSG_W:1]    d,
    output logic [CODE_W-1:0] code
);

    logic p8, p4, p2, p1, p0;

    // Each parity bit covers the codeword positions whose index has that
    // power-of-two bit set.
    assign p8 = ^d[11:5];
    assign p4 = (^d[11:8]) ^ (^d[4:2]);
    assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    assign p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];

`ifdef HAMENC_P0_EN
    assign p0 = calc_p0(d, {p8, p4, p2, p1});
`else
    assign p0 = 1'b0;
`endif

    assign code = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

endmodule

// File: rtl/hamenc_seq.sv
// -----------------------------------------------------------------------------
// hamenc_seq
// Memory-sequencing controller: reads NUM_MSG 11-bit messages (two bytes each
// at SRC_BASE+2i / +2i+1), Hamming-encodes each into a 16-bit codeword and
// writes it to DST_BASE+2i / +2i+1, then raises done.
// Parameters: NUM_MSG (1..127), SRC_BASE, DST_BASE, AW (address width).
// Ports:
//   clk        in       clock, rising edge
//   reset      in       asynchronous, active-high
//   start      in       begins a run when sampled in IDLE or DONE
//   mem_rdata  in  [7:0]     read data, one cycle after its address
//   mem_addr   out [AW-1:0]  byte address
//   mem_we     out           write strobe
//   mem_wdata  out [7:0]     write data
//   busy       out           high in every state except IDLE and DONE
//   done       out           high only in DONE
// Build option HAMENC_P0_EN (inside hamming_enc11) selects SECDED vs SEC.
// -----------------------------------------------------------------------------
module hamenc_seq
    import hamenc_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
    localparam logic [6:0]    LAST_I = 7'(NUM_MSG - 1);

    state_e      state_q, state_d;
    logic [6:0]  i_q, i_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  hi_q, hi_d;

    logic [CODE_W-1:0] code;
    logic [AW-1:0]     idx2;

    // Only the low three bits of the high message byte carry data.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[7:3];

    hamming_enc11 u_enc (
        .d    ({hi_q, lo_q}),
        .code (code)
    );

    // Byte offset of message i; address arithmetic wraps modulo 2^AW.
    assign idx2 = AW'({i_q, 1'b0});

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RD_LO;
            end
            ST_RD_LO: state_d = ST_RD_HI;
            ST_RD_HI: begin
                lo_d    = mem_rdata;          // data for the RD_LO address
                state_d = ST_CAP;
            end
            ST_CAP: begin
                hi_d    = mem_rdata[2:0];     // data for the RD_HI address
                state_d = ST_WR_LO;
            end
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: begin
                if (i_q == LAST_I) begin
                    i_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 7'd1;
                    state_d = ST_RD_LO;
                end
            end
            ST_DONE: begin
                if (start) begin
                    i_d     = '0;
                    state_d = ST_RD_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode of state and i.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_RD_LO: begin
                busy     = 1'b1;
                mem_addr = SRC_A + idx2;
            end
            ST_RD_HI: begin
                busy     = 1'b1;
                mem_addr = SRC_A + idx2 + AW'(1);
            end
            ST_CAP: begin
                busy = 1'b1;
            end
            ST_WR_LO: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_A + idx2;
                mem_wdata = code[7:0];
            end
            ST_WR_HI: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_A + idx2 + AW'(1);
                mem_wdata = code[15:8];
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hamenc_seq.sv
// -----------------------------------------------------------------------------
// tb_hamenc_seq
// Self-checking bench for hamenc_seq with a byte-wide synchronous-read memory
// model. Expected codewords come from a positional Hamming reference model.
// -----------------------------------------------------------------------------
module tb_hamenc_seq;

    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int AW       = 8;
    localparam int LIMIT    = 5 * NUM_MSG + 40;

`ifdef HAMENC_P0_EN
    localparam bit P0_ON = 1'b1;
`else
    localparam bit P0_ON = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;

    logic [7:0] mem [256];

    int vectors;
    int miscompares;

    hamenc_seq #(
        .NUM_MSG  (NUM_MSG),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .AW       (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference: data bits fill non-power-of-two positions 3..15 in order;
    // parity at position 2^k is the XOR of all positions with bit k set;
    // position 0 is the XOR of positions 1..15 when SECDED is built.
    function automatic logic [15:0] ref_code(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic x;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int j = 1; j < 16; j++)
                if ((j & p) != 0) x = x ^ c[j];
            c[p] = x;
        end
        if (P0_ON) c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Starts a run, optionally toggles start randomly while busy, and returns
    // the edge index at which done was first seen plus busy/write counts.
    task automatic run_msgs(input bit noisy, output int done_at,
                            output int busy_n, output int wr_n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        done_at = -1;
        busy_n  = 0;
        wr_n    = 0;
        for (int n = 1; n <= LIMIT; n++) begin
            if (done) begin
                start   = 1'b0;
                done_at = n - 1;
                break;
            end
            if (busy)   busy_n++;
            if (mem_we) wr_n++;
            if (noisy)  start = 1'b1 & $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (done_at < 0) fail_now("run_timeout");
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp_code;   // SECDED value; bit 0 cleared for SEC builds
        string       name;
    } vec_t;

    vec_t vecs[4];
    logic [10:0] msgs [NUM_MSG];

    initial begin
        int done_at, busy_n, wr_n;
        logic [15:0] exp;
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        reset       = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        vecs[0] = '{8'h00, 8'h00, 16'h0000, "zero"};
        vecs[1] = '{8'hFF, 8'h07, 16'hFFFF, "all_ones"};
        vecs[2] = '{8'h01, 8'h00, 16'h000F, "d1_only"};
        vecs[3] = '{8'h00, 8'hFC, 16'h8117, "d11_upper_ignored"};

        repeat (3) @(posedge clk);
        #1;
        check("reset_addr",  32'(mem_addr),  32'h0);
        check("reset_we",    32'(mem_we),    32'h0);
        check("reset_wdata", 32'(mem_wdata), 32'h0);
        check("reset_busy",  32'(busy),      32'h0);
        check("reset_done",  32'(done),      32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors, each as message 0 of a fresh run from IDLE.
        for (int v = 0; v < 4; v++) begin
            mem[SRC_BASE]     = vecs[v].lo;
            mem[SRC_BASE + 1] = vecs[v].hi;
            run_msgs(1'b0, done_at, busy_n, wr_n);
            exp = vecs[v].exp_code;
            if (!P0_ON) exp[0] = 1'b0;
            check({vecs[v].name, "_lo"}, 32'(mem[DST_BASE]),     32'(exp[7:0]));
            check({vecs[v].name, "_hi"}, 32'(mem[DST_BASE + 1]), 32'(exp[15:8]));
            if (v == 0) begin
                check("done_edge",   32'(done_at), 32'(5 * NUM_MSG));
                check("busy_cycles", 32'(busy_n),  32'(5 * NUM_MSG));
                check("write_count", 32'(wr_n),    32'(2 * NUM_MSG));
            end
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end

        // Random messages with start noise while busy; run begins from IDLE,
        // the second random run begins from DONE.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_MSG; i++) begin
                msgs[i] = 11'($urandom);
                mem[SRC_BASE + 2*i]     = msgs[i][7:0];
                mem[SRC_BASE + 2*i + 1] = {5'($urandom), msgs[i][10:8]};
            end
            run_msgs(1'b1, done_at, busy_n, wr_n);
            check("rand_done_edge",   32'(done_at), 32'(5 * NUM_MSG));
            check("rand_busy_cycles", 32'(busy_n),  32'(5 * NUM_MSG));
            check("rand_write_count", 32'(wr_n),    32'(2 * NUM_MSG));
            for (int i = 0; i < NUM_MSG; i++) begin
                exp = ref_code(msgs[i]);
                check($sformatf("rand%0d_m%0d_lo", r, i), 32'(mem[DST_BASE + 2*i]),     32'(exp[7:0]));
                check($sformatf("rand%0d_m%0d_hi", r, i), 32'(mem[DST_BASE + 2*i + 1]), 32'(exp[15:8]));
            end
        end

        // Reset while message 2 is in CAP: outputs drop, no further writes.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            msgs[i] = 11'($urandom);
            mem[SRC_BASE + 2*i]     = msgs[i][7:0];
            mem[SRC_BASE + 2*i + 1] = {5'b0, msgs[i][10:8]};
        end
        for (int a = DST_BASE; a < DST_BASE + 2*NUM_MSG; a++) mem[a] = 8'hA5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                 // E0
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);     // E12: now in cycle 13
        #1;
        check("pre_abort_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_addr",  32'(mem_addr),  32'h0);
        check("abort_we",    32'(mem_we),    32'h0);
        check("abort_wdata", 32'(mem_wdata), 32'h0);
        check("abort_busy",  32'(busy),      32'h0);
        check("abort_done",  32'(done),      32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_write", 32'(mem_we), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("idle_after_abort", 32'({busy, done, mem_we}), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            exp = ref_code(msgs[i]);
            check($sformatf("abort_m%0d_lo", i), 32'(mem[DST_BASE + 2*i]),     32'(exp[7:0]));
            check($sformatf("abort_m%0d_hi", i), 32'(mem[DST_BASE + 2*i + 1]), 32'(exp[15:8]));
        end
        check("abort_keep_lo", 32'(mem[DST_BASE + 4]), 32'hA5);
        check("abort_keep_hi", 32'(mem[DST_BASE + 5]), 32'hA5);

        run_msgs(1'b0, done_at, busy_n, wr_n);
        check("rerun_done_edge",   32'(done_at), 32'(5 * NUM_MSG));
        check("rerun_write_count", 32'(wr_n),    32'(2 * NUM_MSG));
        for (int i = 0; i < NUM_MSG; i++) begin
            exp = ref_code(msgs[i]);
            check($sformatf("rerun_m%0d", i),
                  32'({mem[DST_BASE + 2*i + 1], mem[DST_BASE + 2*i]}), 32'(exp));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
